// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: op codes, FSM states, default width.
package alu_arb_pkg;

  localparam int W_DEF = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      cand = sum[PW-1:0];
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU among NREQ requesters.
// Optional ALU_DIVZERO_CHK_EN: DIV by zero returns rsp_y=FF with rsp_err=1, skipping SETTLE.
//   state  | meaning
//   IDLE   | wait for any req; arbitrate, latch operands, pulse gnt
//   EXEC   | ALU evaluating; fast ops captured here
//   SETTLE | extra cycle before capturing MUL/DIV
//   DONE   | gap cycle so the winner can drop req
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic [NREQ-1:0] gnt,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [2:0]      alu_op,
  input  logic [W-1:0]    alu_y,
  output logic [NREQ-1:0] rsp_valid,
  output logic [W-1:0]    rsp_y,
  output logic            rsp_err,
  output logic            busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, idx_q, idx_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, y_q, y_d;
  logic [2:0]      op_q, op_d;
  logic [NREQ-1:0] gnt_q, gnt_d, rv_q, rv_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] arb_gnt, idx_oh;
  logic [PW-1:0]   arb_idx;
  logic            arb_any, div_zero, slow_op;
  logic [W-1:0]    a_arr  [NREQ];
  logic [W-1:0]    b_arr  [NREQ];
  logic [2:0]      op_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i]  = req_a[i*W +: W];
    assign b_arr[i]  = req_b[i*W +: W];
    assign op_arr[i] = req_op[i*3 +: 3];
  end

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr_arbiter (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

`ifdef ALU_DIVZERO_CHK_EN
  assign div_zero = (op_q == OP_DIV) && (b_q == '0);
`else
  assign div_zero = 1'b0;
`endif
  assign slow_op = (op_q == OP_MUL) || (op_q == OP_DIV);

  always_comb begin
    idx_oh        = '0;
    idx_oh[idx_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    y_d     = y_q;
    err_d   = err_q;
    gnt_d   = '0;
    rv_d    = '0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          a_d     = a_arr[arb_idx];
          b_d     = b_arr[arb_idx];
          op_d    = op_arr[arb_idx];
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          ptr_d   = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (div_zero) begin
          y_d     = '1;
          err_d   = 1'b1;
          rv_d    = idx_oh;
          state_d = DONE;
        end else if (slow_op) begin
          state_d = SETTLE;
        end else begin
          y_d     = alu_y;
          err_d   = 1'b0;
          rv_d    = idx_oh;
          state_d = DONE;
        end
      end
      SETTLE: begin
        y_d     = alu_y;
        err_d   = 1'b0;
        rv_d    = idx_oh;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      y_q     <= '0;
      err_q   <= 1'b0;
      gnt_q   <= '0;
      rv_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      y_q     <= y_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
      rv_q    <= rv_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rv_q;
  assign rsp_y     = y_q;
  assign rsp_err   = err_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-timeline model plus directed literal checks.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
`ifdef ALU_DIVZERO_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]   req, gnt, rsp_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N*3-1:0] req_op;
  logic [W-1:0]   alu_a, alu_b, alu_y, rsp_y;
  logic [2:0]     alu_op;
  logic           rsp_err, busy;

  logic [N-1:0] drv_req = '0;
  logic [W-1:0] drv_a [N];
  logic [W-1:0] drv_b [N];
  logic [2:0]   drv_op [N];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return p[7:0];
      3'b011:  return (b == 8'h00) ? 8'h00 : a / b;
      3'b100:  return a & b;
      3'b101:  return a | b;
      3'b110:  return ~a;
      default: return a ^ b;
    endcase
  endfunction

  always_comb begin
    req = drv_req;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = drv_a[i];
      req_b[i*W +: W] = drv_b[i];
      req_op[i*3 +: 3] = drv_op[i];
    end
  end

  always_comb alu_y = alu_ref(alu_a, alu_b, alu_op);

  alu_arbiter #(.NREQ(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .gnt       (gnt),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  // model: one transaction in flight, described by when it answers and when the next grant may occur
  logic [N-1:0] exp_gnt, exp_rv;
  logic [7:0]   exp_a, exp_b, exp_y, m_res;
  logic [2:0]   exp_op;
  logic         exp_err, m_err, exp_busy;
  int m_ptr, m_idx, rsp_cyc, nxt_ok, busy_last;
  bit pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; pend = 0; nxt_ok = 0; busy_last = -1; m_idx = 0;
    exp_a = '0; exp_b = '0; exp_op = '0; exp_y = '0; exp_err = 1'b0;
    exp_gnt = '0; exp_rv = '0; exp_busy = 1'b0; m_res = '0; m_err = 1'b0; rsp_cyc = 0;
  endtask

  task automatic model_eval();
    int w, lat;
    bit dz;
    exp_gnt = '0;
    exp_rv  = '0;
    if (pend && cyc == rsp_cyc) begin
      exp_rv[m_idx] = 1'b1;
      exp_y = m_res;
      exp_err = m_err;
      pend = 0;
    end
    if (cyc >= nxt_ok && drv_req != '0) begin
      w = first_from(drv_req, m_ptr);
      m_ptr = (w + 1) % N;
      m_idx = w;
      exp_gnt[w] = 1'b1;
      exp_a = drv_a[w]; exp_b = drv_b[w]; exp_op = drv_op[w];
      dz = CHK && exp_op == OP_DIV && exp_b == 8'h00;
      if (dz) begin
        m_res = 8'hFF; m_err = 1'b1; lat = 1;
      end else begin
        m_res = alu_ref(exp_a, exp_b, exp_op); m_err = 1'b0;
        lat = (exp_op == OP_MUL || exp_op == OP_DIV) ? 2 : 1;
      end
      pend = 1;
      rsp_cyc = cyc + lat;
      busy_last = rsp_cyc;
      nxt_ok = rsp_cyc + 2;
    end
    exp_busy = (cyc <= busy_last);
  endtask

  task automatic compare();
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("alu_a", 32'(alu_a), 32'(exp_a));
    chk("alu_b", 32'(alu_b), 32'(exp_b));
    chk("alu_op", 32'(alu_op), 32'(exp_op));
    chk("rsp_y", 32'(rsp_y), 32'(exp_y));
    if (exp_rv != '0) chk("rsp_err", 32'(rsp_err), 32'(exp_err));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    model_eval();
    compare();
  endtask

  task automatic run_txn(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         output int gl, output int rl, output logic [7:0] y, output logic e);
    int s, gc, rc;
    s = cyc; gc = -1; rc = -1; y = '0; e = 1'b0;
    drv_a[i] = a; drv_b[i] = b; drv_op[i] = op; drv_req[i] = 1'b1;
    for (int k = 0; k < 20 && rc < 0; k++) begin
      step();
      if (gnt[i]) begin
        gc = cyc;
        drv_a[i] = ~a;
        drv_b[i] = b ^ 8'h5A;
      end
      if (rsp_valid[i]) begin
        rc = cyc; y = rsp_y; e = rsp_err; drv_req[i] = 1'b0;
      end
    end
    chk("txn_done", 32'(rc >= 0 && gc >= 0), 32'd1);
    drv_req[i] = 1'b0;
    gl = gc - s;
    rl = rc - gc;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gl, rl, done, gi;
    logic [7:0] y;
    logic e;
    logic [7:0] ys [N];
    int order[$];
    bit granted [N];

    for (int i = 0; i < N; i++) begin
      drv_a[i] = '0; drv_b[i] = '0; drv_op[i] = '0; granted[i] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_txn(0, 8'd7, 8'd3, OP_ADD, gl, rl, y, e);
    chk("add_gnt_lat", 32'(gl), 32'd1);
    chk("add_rsp_lat", 32'(rl), 32'd1);
    chk("add_y", 32'(y), 32'h0A);
    step();
    chk("add_busy_t3", 32'(busy), 32'd0);

    run_txn(2, 8'd7, 8'd3, OP_MUL, gl, rl, y, e);
    chk("mul_rsp_lat", 32'(rl), 32'd2);
    chk("mul_y", 32'(y), 32'h15);

    run_txn(1, 8'd3, 8'd7, OP_SUB, gl, rl, y, e);
    chk("sub_y", 32'(y), 32'hFC);

    run_txn(3, 8'd9, 8'd0, OP_DIV, gl, rl, y, e);
    chk("div0_lat", 32'(rl), CHK ? 32'd1 : 32'd2);
    chk("div0_err", 32'(e), CHK ? 32'd1 : 32'd0);
    chk("div0_y", 32'(y), CHK ? 32'hFF : 32'h00);

    // all four requesting from reset
    rst_n = 1'b0; model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    drv_a[0] = 8'd1;   drv_b[0] = 8'd2;   drv_op[0] = OP_ADD;
    drv_a[1] = 8'd10;  drv_b[1] = 8'd4;   drv_op[1] = OP_SUB;
    drv_a[2] = 8'd5;   drv_b[2] = 8'd6;   drv_op[2] = OP_MUL;
    drv_a[3] = 8'hF0;  drv_b[3] = 8'h3C;  drv_op[3] = OP_XOR;
    drv_req = '1;
    done = 0;
    for (int k = 0; k < 40 && done < N; k++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) order.push_back(i);
        if (rsp_valid[i]) begin ys[i] = rsp_y; drv_req[i] = 1'b0; done++; end
      end
    end
    chk("all4_count", 32'(done), 32'd4);
    for (int k = 0; k < N; k++)
      chk("all4_order", (k < order.size()) ? 32'(order[k]) : 32'hFFFF, 32'(k));
    chk("all4_y0", 32'(ys[0]), 32'h03);
    chk("all4_y1", 32'(ys[1]), 32'h06);
    chk("all4_y2", 32'(ys[2]), 32'h1E);
    chk("all4_y3", 32'(ys[3]), 32'hCC);
    step();

    // requesters 1 and 3 held high continuously
    order.delete();
    drv_op[1] = OP_ADD; drv_op[3] = OP_OR;
    drv_req = 4'b1010;
    for (int k = 0; k < 16; k++) begin
      step();
      for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
    end
    drv_req = '0;
    for (int k = 0; k < 4; k++)
      chk("alt_order", (k < order.size()) ? 32'(order[k]) : 32'hFFFF, (k % 2 == 0) ? 32'd1 : 32'd3);
    repeat (5) step();

    // reset while a MUL sits in SETTLE
    drv_a[2] = 8'd7; drv_b[2] = 8'd3; drv_op[2] = OP_MUL; drv_req[2] = 1'b1;
    gi = -1;
    for (int k = 0; k < 10 && gi < 0; k++) begin
      step();
      if (gnt[2]) gi = cyc;
    end
    chk("rst_mid_granted", 32'(gi >= 0), 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_mid_alu_a", 32'(alu_a), 32'd0);
    chk("rst_mid_alu_op", 32'(alu_op), 32'd0);
    chk("rst_mid_rv", 32'(rsp_valid), 32'd0);
    model_reset();
    drv_a[0] = 8'h11; drv_b[0] = 8'h22; drv_op[0] = OP_AND;
    drv_req = 4'b0101;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    gi = -1;
    for (int k = 0; k < 10 && gi < 0; k++) begin
      step();
      if (gnt != '0) gi = cyc;
      else chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("rst_first_gnt", 32'(gnt), 32'b0001);
    done = 0;
    for (int k = 0; k < 20 && done < 2; k++) begin
      if (rsp_valid[0]) begin drv_req[0] = 1'b0; done++; end
      if (rsp_valid[2]) begin drv_req[2] = 1'b0; done++; end
      if (done < 2) step();
    end
    drv_req = '0;
    repeat (5) step();

    // randomized requesters driven from the model's view of grants and responses
    for (int t = 0; t < 1500; t++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (exp_gnt[i]) begin
          granted[i] = 1;
          drv_a[i] = W'($urandom);
          drv_b[i] = W'($urandom);
        end
        if (exp_rv[i]) begin
          drv_req[i] = 1'b0;
          granted[i] = 0;
        end else if (!drv_req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            drv_a[i] = W'($urandom);
            drv_b[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
            drv_op[i] = 3'($urandom_range(0, 7));
            drv_req[i] = 1'b1;
          end
        end else if (!granted[i] && $urandom_range(0, 15) == 0) begin
          drv_req[i] = 1'b0;
        end
      end
    end
    drv_req = '0;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 8-bit `alu` instance between `NREQ` requesters. Each requester presents operands and a 3-bit op code. A round-robin FSM grants one requester at a time, drives the ALU, captures the result, and returns it to the winner with a one-cycle valid pulse. The block sits between the requesting datapath units and the existing combinational `alu`, which is instantiated alongside this block, not inside it.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8
- `W`, 8: operand/result width; must match `alu`

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req` in NREQ: request per requester; held high until the requester's `rsp_valid` pulse
- `req_a` in NREQ*W: operand a, requester i at bits [i*W +: W]
- `req_b` in NREQ*W: operand b, same packing
- `req_op` in NREQ*3: op code, requester i at bits [i*3 +: 3]
- `gnt` out NREQ: one-hot, one-cycle pulse; operands were captured
- `alu_a` out W: to `alu.a`
- `alu_b` out W: to `alu.b`
- `alu_op` out 3: to `alu.op`
- `alu_y` in W: from `alu.y`
- `rsp_valid` out NREQ: one-hot, one-cycle result pulse
- `rsp_y` out W: result; held until the next capture
- `rsp_err` out 1: error flag, qualified by `rsp_valid`
- `busy` out 1: high when state != IDLE

## Operation
- Op codes (ALU-defined): 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 NOT a, 111 XOR.
- Results are truncated to W bits. SUB wraps (3-7 = 8'hFC). MUL keeps the low W bits.
- FSM states and transitions:
  - IDLE: if any `req` is set, pick the winner with round-robin from pointer `ptr`. Latch the winner's a/b/op into the `alu_*` registers, pulse `gnt[idx]`, store `idx`, and go to EXEC.
  - EXEC: if op is MUL or DIV, go to SETTLE. Otherwise capture `alu_y` into `rsp_y`, pulse `rsp_valid[idx]`, and go to DONE.
  - SETTLE: capture `alu_y`, pulse `rsp_valid[idx]`, go to DONE.
  - DONE: go to IDLE. This cycle lets a registered requester drop `req`.
- `ptr` moves to (idx+1) mod NREQ on every grant. No requester waits more than NREQ-1 grants.
- `alu_*` registers hold their values from grant until the next grant. They are never changed mid-operation.
- A `req` dropped before it is granted is ignored; no response is produced.
- If `req` is still high when the FSM re-enters IDLE, it is treated as a new request.
- Operand changes after `gnt` have no effect on the current operation.

## Timing
- Grant edge = k:
  - fast ops: `rsp_valid` is high in the cycle after edge k+1
  - MUL/DIV: `rsp_valid` is high after edge k+2
- Throughput: one op per 3 cycles (fast) or 4 cycles (MUL/DIV).
- IDLE with `req` high → `gnt` is seen after the next edge. Arbitration adds 1 cycle.
- Reset values: `gnt`=0, `rsp_valid`=0, `rsp_y`=0, `rsp_err`=0, `alu_a`=0, `alu_b`=0, `alu_op`=000, `busy`=0, `ptr`=0, state=IDLE.
- Reset asserted mid-operation: outputs go to their reset values immediately and asynchronously. The pending operation is dropped and no `rsp_valid` is produced.

## Configuration
- `ALU_DIVZERO_CHK_EN` defined:
  - DIV with b=0 is not evaluated; EXEC goes directly to DONE.
  - `rsp_y`=8'hFF and `rsp_err`=1 with `rsp_valid[idx]`, one cycle after grant.
- `ALU_DIVZERO_CHK_EN` undefined:
  - `rsp_err` is tied to 0.
  - DIV by zero follows the normal SETTLE path and returns whatever `alu_y` holds.

## Structure
- Package `alu_arb_pkg` holds:
  - op-code localparams `OP_ADD`..`OP_XOR`
  - FSM state enum (IDLE, EXEC, SETTLE, DONE)
  - default width `W_DEF`=8
- Sub-module `rr_arbiter` is combinational. It takes `req` and `ptr`, and returns the one-hot grant, `idx`, and an any-request flag.

## Test plan
- req[0], ADD a=7, b=3 → `gnt[0]` at cycle t; `rsp_valid[0]` at t+1; `rsp_y`=8'h0A; `busy` low at t+3.
- req[2], MUL a=7, b=3 → `rsp_valid[2]` at t+2, `rsp_y`=8'h15. SUB a=3, b=7 → `rsp_y`=8'hFC.
- All four `req` high after reset, each held until served → grant order 0, 1, 2, 3, each with the correct result.
- `req[1]` and `req[3]` re-asserted continuously → grants alternate 1, 3, 1, 3; no starvation.
- DIV a=9, b=0:
  - with `ALU_DIVZERO_CHK_EN` → `rsp_y`=8'hFF, `rsp_err`=1, `rsp_valid` at t+1
  - without → `rsp_err`=0, `rsp_valid` at t+2
- `rst_n` low during SETTLE → all outputs 0 immediately; no `rsp_valid` after release; next grant goes to requester 0.
